// File: rtl/mem_init_pkg.sv
// mem_init_pkg: state encoding, bus strobe constants and sizing helper shared by the copier
package mem_init_pkg;
   typedef enum logic [2:0] {IDLE, RD, WR, ZERO, DONE, ERR} state_t;
   localparam logic [3:0] WSTRB_READ = 4'h0;
   localparam logic [3:0] WSTRB_WORD = 4'hF;
   function automatic logic [31:0] words_ceil(input logic [31:0] bytes);
      return (bytes >> 2) + {31'd0, |bytes[1:0]};
   endfunction
endpackage

// File: rtl/mem_init_watchdog.sv
// mem_init_watchdog: flags a request that has waited TIMEOUT_CYCLES cycles without ready
module mem_init_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic clk,
   input  logic resetn,
   input  logic active,
   input  logic ack,
   output logic expired
);
   logic [31:0] cnt;
   // count stalled cycles; any accepted or idle cycle restarts the count
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) cnt <= '0;
      else cnt <= (active && !ack) ? cnt + 32'd1 : '0;
   assign expired = active && !ack && (cnt == TIMEOUT_CYCLES - 32'd1);
endmodule

// File: rtl/mem_init_copier.sv
// mem_init_copier: copies .data from ROM to RAM, zero-fills .bss, then releases the CPU reset
module mem_init_copier
   import mem_init_pkg::*;
#(
   parameter logic [31:0] DATA_LMA       = 32'h0000_c430,
   parameter logic [31:0] DATA_START     = 32'h0002_0000,
   parameter logic [31:0] DATA_END       = 32'h0002_09b0,
   parameter logic [31:0] BSS_END        = 32'h0002_09b0,
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic        clk,
   input  logic        resetn,
   output logic        mem_valid,
   output logic        mem_instr,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   output logic        done,
   output logic        err,
   output logic        cpu_resetn
);
   localparam logic [31:0] NCOPY  = words_ceil(DATA_END - DATA_START);
   localparam logic [31:0] NZERO  = words_ceil(BSS_END - DATA_END);
   localparam logic [31:0] NTOTAL = NCOPY + NZERO;
   state_t      state, state_n;
   logic [31:0] idx, idx_n, addr_n, wdata_n;
   logic [3:0]  wstrb_n;
   logic        valid_n, accept, expired, busy;
   assign accept    = mem_valid && mem_ready;
   assign busy      = state == RD || state == WR || state == ZERO;
   assign mem_instr = 1'b0;
   mem_init_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
      .clk(clk),
      .resetn(resetn),
      .active(mem_valid),
      .ack(mem_ready),
      .expired(expired)
   );
   // next state, word index and the request fields to present on the following edge;
   // the zero-fill index simply continues past NCOPY so its address follows the copy
   always_comb begin
      state_n = state;
      idx_n   = idx;
      wdata_n = mem_wdata;
      case (state)
         IDLE: state_n = (NCOPY != 0) ? RD : (NZERO != 0) ? ZERO : DONE;
         RD: if (accept) begin
            wdata_n = mem_rdata;
            state_n = WR;
         end
         WR: if (accept) begin
            idx_n   = idx + 32'd1;
            state_n = (idx_n != NCOPY) ? RD : (NZERO != 0) ? ZERO : DONE;
         end
         ZERO: if (accept) begin
            idx_n   = idx + 32'd1;
            state_n = (idx_n != NTOTAL) ? ZERO : DONE;
         end
         default: ;
      endcase
      if (expired) state_n = ERR;
      valid_n = busy && !accept && !expired;
      addr_n  = (state_n == RD) ? DATA_LMA + (idx_n << 2) :
                (state_n == WR || state_n == ZERO) ? DATA_START + (idx_n << 2) : mem_addr;
      wstrb_n = (state_n == RD) ? WSTRB_READ :
                (state_n == WR || state_n == ZERO) ? WSTRB_WORD : mem_wstrb;
      if (state_n == ZERO) wdata_n = '0;
   end
   // state, index, bus request and status registers, all cleared asynchronously
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         state      <= IDLE;
         idx        <= '0;
         mem_valid  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_wstrb  <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
         cpu_resetn <= 1'b0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         mem_valid  <= valid_n;
         mem_addr   <= addr_n;
         mem_wdata  <= wdata_n;
         mem_wstrb  <= wstrb_n;
         done       <= state_n == DONE;
         err        <= state_n == ERR;
         cpu_resetn <= state_n == DONE;
      end
endmodule

// File: doc/mem_init_copier.md
# mem_init_copier

Bus-initiator that performs the C-runtime memory initialisation in hardware before the CPU runs. After reset it copies the `.data` image from its ROM load address to its RAM run address, zero-fills `.bss`, then releases the CPU's reset. It drives the same picorv32 native memory interface (`mem_valid`/`mem_ready`) that the system memory responds to, and sits in front of the memory arbiter while the CPU is still held in reset.

## Interface
- `DATA_LMA`, 32'h0000_c430, ROM byte address of the `.data` image; word-aligned.
- `DATA_START`, 32'h0002_0000, RAM byte address of `.data`; word-aligned.
- `DATA_END`, 32'h0002_09b0, end of `.data`, exclusive; at least `DATA_START`.
- `BSS_END`, 32'h0002_09b0, end of `.bss`, exclusive; at least `DATA_END`. Equal to `DATA_END` means no zero-fill.
- `TIMEOUT_CYCLES`, 1023, maximum cycles a request may wait for `mem_ready`; at least 1.
- `clk`  in  1  system clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `mem_valid`  out  1  request valid.
- `mem_instr`  out  1  always 0.
- `mem_ready`  in  1  responder accepts/completes the request.
- `mem_addr`  out  32  byte address, word-aligned.
- `mem_wdata`  out  32  write data.
- `mem_wstrb`  out  4  4'h0 = read, 4'hF = write.
- `mem_rdata`  in  32  read data, valid when `mem_ready`=1.
- `done`  out  1  initialisation complete; sticky until reset.
- `err`  out  1  handshake timeout; sticky until reset.
- `cpu_resetn`  out  1  CPU reset release, registered; equals `done`.

## Operation
- Copy count: NCOPY = ceil((DATA_END−DATA_START)/4) words. A partial final word is copied whole.
- Zero count: NZERO = ceil((BSS_END−DATA_END)/4) words. Zero-fill starts at address DATA_START + 4·NCOPY.
- States:
  - `IDLE` is entered on reset and lasts one cycle. It goes to `RD` if NCOPY>0, else to `ZERO` if NZERO>0, else to `DONE`.
  - `RD` issues a read at DATA_LMA+4·i. On `mem_ready` it latches `mem_rdata` into a holding register and goes to `WR`.
  - `WR` issues a write at DATA_START+4·i with `mem_wdata` = holding register and `mem_wstrb`=4'hF. On `mem_ready` it increments i. It goes to `RD` if i<NCOPY, else to `ZERO` if NZERO>0, else to `DONE`.
  - `ZERO` issues a write at the zero-fill address with `mem_wdata`=0 and `mem_wstrb`=4'hF. On `mem_ready` it advances; after NZERO writes it goes to `DONE`.
  - `DONE` sets `done`=1 and `cpu_resetn`=1 and holds `mem_valid`=0 forever.
  - `ERR` sets `err`=1 and holds `mem_valid`=0, `done`=0, `cpu_resetn`=0 forever.
- Index and address arithmetic is 32-bit unsigned and wraps modulo 2^32. There is no bounds checking.
- Watchdog:
  - Counts cycles with `mem_valid`=1 and `mem_ready`=0; clears on each accepted transfer.
  - Reaching TIMEOUT_CYCLES deasserts `mem_valid` on the next edge and enters `ERR`.
  - If `mem_ready` and timeout occur in the same cycle, `mem_ready` wins.
- Reset asserted mid-operation:
  - All state clears asynchronously.
  - After `resetn` rises, the copy restarts from i=0. No partial progress is retained.

## Timing
- Reset values: `mem_valid`=0, `mem_instr`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wstrb`=0, `done`=0, `err`=0, `cpu_resetn`=0.
- All outputs are registered.
- Handshake:
  - `mem_addr`, `mem_wdata` and `mem_wstrb` are stable from the rising edge of `mem_valid` until `mem_ready` is sampled high.
  - On the edge that samples `mem_ready`=1, `mem_valid` falls.
  - The next request's `mem_valid` rises on the following edge, so there is exactly one idle cycle between transfers.
  - `mem_ready` sampled while `mem_valid`=0 is ignored.
- Cycles per transfer are W+3, where W is the responder's ready latency counted from `mem_valid` rising. W=0 for a responder that registers `mem_ready` one cycle after seeing `mem_valid`.
- With that responder and the default parameters: NCOPY=620, 6 cycles per word, `done` rises about 3722 cycles after reset release.

## Structure
- Shared package `mem_init_pkg` holds:
  - the state enum (`IDLE`, `RD`, `WR`, `ZERO`, `DONE`, `ERR`);
  - the bus constants `WSTRB_READ`=4'h0 and `WSTRB_WORD`=4'hF;
  - the function `words_ceil(bytes)`.
- Sub-module `mem_init_watchdog` contains the timeout counter, with inputs `active` and `ack` and output `expired`.
- The FSM and address generation stay in the top level.

## Test plan
- **Default copy:**
  - Stimulus: defaults, 1-cycle registered responder, LMA region preloaded with word index.
  - Required: first read at 0xc430; first write at 0x20000 carrying mem[0xc430>>2].
  - Required: all 620 destination words match, `done` at cycle ~3722, `err`=0.
- **Partial word:**
  - Stimulus: DATA_END−DATA_START=6.
  - Required: exactly 2 word copies; the word at DATA_START+8 is untouched; no zero writes.
- **Zero-fill:**
  - Stimulus: BSS_END=DATA_END+8 on the default layout.
  - Required: after the last copy, writes of 0 with wstrb F at 0x209b0 and 0x209b4, then `done`.
- **Random stall:**
  - Stimulus: responder latency randomised over 0–5 cycles.
  - Required: addr/wdata/wstrb are constant while valid=1 and ready=0.
  - Required: valid is low for exactly 1 cycle between transfers; destination contents are still correct.
- **Timeout:**
  - Stimulus: responder never asserts ready, TIMEOUT_CYCLES=16.
  - Required: `err`=1 and `mem_valid`=0 after 16 stalled cycles; `cpu_resetn` stays 0.
- **Reset mid-copy:**
  - Stimulus: `resetn` pulled low at word 100.
  - Required: outputs go to reset values immediately, without waiting for a clock edge.
  - Required: after release, the next read is at 0xc430 and the run completes correctly.
